dmem_arbiter: RTL

Two-port arbiter and access sequencer for the pipeline's data memory. It shares one memory port between requester A (core LSU) and requester B (debug/program loader) with round-robin arbitration. It decodes each access into the memory's control signals: func3, address, write data, aligned and misaligned byte masks, and wren/rden. It returns the registered read data to the winning requester through a req/ack handshake.

---
 rtl/dmem_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares the single data-memory port between requester A
//                (core LSU) and requester B (debug / program loader) using
//                round-robin arbitration. Each access is a 3-cycle slot:
//                IDLE (sample + latch) -> ISSUE (memory strobe) -> RESP (ack).
//                The access is decoded into func3, address, write data,
//                aligned/misaligned byte masks and wren/rden.
//  Ports       : i_clk, i_reset (sync, active-low)
//                i_req_x / i_we_x / i_func3_x / i_addr_x / i_wdata_x  (x=a,b)
//                o_ack_x / o_err_x / o_rdata_x                        (x=a,b)
//                o_mem_func3, o_mem_addr, o_mem_wdata,
//                o_mem_bmask_align, o_mem_bmask_misalign,
//                o_mem_wren, o_mem_rden, i_mem_rdata
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_a,
    input  logic        i_req_b,
    input  logic        i_we_a,
    input  logic        i_we_b,
    input  logic [2:0]  i_func3_a,
    input  logic [2:0]  i_func3_b,
    input  logic [15:0] i_addr_a,
    input  logic [15:0] i_addr_b,
    input  logic [31:0] i_wdata_a,
    input  logic [31:0] i_wdata_b,
    output logic        o_ack_a,
    output logic        o_ack_b,
    output logic        o_err_a,
    output logic        o_err_b,
    output logic [31:0] o_rdata_a,
    output logic [31:0] o_rdata_b,
    output logic [2:0]  o_mem_func3,
    output logic [15:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask_align,
    output logic [3:0]  o_mem_bmask_misalign,
    output logic        o_mem_wren,
    output logic        o_mem_rden,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      state;
    logic        ptr;        // 0 = A has priority, 1 = B has priority
    logic        port_b;     // latched winner: 1 = B
    logic        acc_we;     // latched store flag
    logic        acc_err;    // latched illegal-func3 flag

    logic        grant_b;
    logic        sel_we;
    logic [2:0]  sel_func3;
    logic [15:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_legal;
    logic [3:0]  offset;
    logic [3:0]  align;
    logic [3:0]  misalign;

    // Winner selection and decode of the winning request's fields.
    always_comb begin
        grant_b   = i_req_b & (~i_req_a | ptr);
        sel_we    = grant_b ? i_we_b    : i_we_a;
        sel_func3 = grant_b ? i_func3_b : i_func3_a;
        sel_addr  = grant_b ? i_addr_b  : i_addr_a;
        sel_wdata = grant_b ? i_wdata_b : i_wdata_a;

        if (sel_we)
            sel_legal = (sel_func3 == 3'b000) || (sel_func3 == 3'b001) ||
                        (sel_func3 == 3'b010);
        else
            sel_legal = (sel_func3 == 3'b000) || (sel_func3 == 3'b001) ||
                        (sel_func3 == 3'b010) || (sel_func3 == 3'b100) ||
                        (sel_func3 == 3'b101);

        // Offset widened to 4 bits so shifts truncate into the 4-lane mask.
        offset   = {2'b00, sel_addr[1:0]};
        align    = 4'b0000;
        misalign = 4'b0000;
        if (sel_we) begin
            case (sel_func3[1:0])
                2'b00: align = 4'b0001 << offset;
                2'b01: begin
                    if (offset == 4'd3) begin
                        align    = 4'b1000;
                        misalign = 4'b0001;
                    end else begin
                        align = 4'b0011 << offset;
                    end
                end
                2'b10: begin
                    align    = 4'b1111 << offset;
                    misalign = (4'b0001 << offset) - 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state                <= IDLE;
            ptr                  <= 1'b0;
            port_b               <= 1'b0;
            acc_we               <= 1'b0;
            acc_err              <= 1'b0;
            o_ack_a              <= 1'b0;
            o_ack_b              <= 1'b0;
            o_err_a              <= 1'b0;
            o_err_b              <= 1'b0;
            o_mem_func3          <= 3'b000;
            o_mem_addr           <= 16'h0000;
            o_mem_wdata          <= 32'h0000_0000;
            o_mem_bmask_align    <= 4'b0000;
            o_mem_bmask_misalign <= 4'b0000;
            o_mem_wren           <= 1'b0;
            o_mem_rden           <= 1'b0;
        end else begin
            // Memory outputs and ack/err are single-cycle: zero unless set below.
            o_ack_a              <= 1'b0;
            o_ack_b              <= 1'b0;
            o_err_a              <= 1'b0;
            o_err_b              <= 1'b0;
            o_mem_func3          <= 3'b000;
            o_mem_addr           <= 16'h0000;
            o_mem_wdata          <= 32'h0000_0000;
            o_mem_bmask_align    <= 4'b0000;
            o_mem_bmask_misalign <= 4'b0000;
            o_mem_wren           <= 1'b0;
            o_mem_rden           <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (i_req_a | i_req_b) begin
                        port_b  <= grant_b;
                        acc_we  <= sel_we;
                        acc_err <= ~sel_legal;
                        ptr     <= ~ptr;
                        state   <= ISSUE;
                        // Memory outputs are loaded here so they are
                        // registered and visible throughout ISSUE.
                        if (sel_legal) begin
                            o_mem_func3          <= sel_func3;
                            o_mem_addr           <= sel_addr;
                            o_mem_wdata          <= sel_wdata;
                            o_mem_bmask_align    <= align;
                            o_mem_bmask_misalign <= misalign;
                            o_mem_wren           <= sel_we;
                            o_mem_rden           <= ~sel_we;
                        end
                    end
                end
                ISSUE: begin
                    o_ack_a <= ~port_b;
                    o_ack_b <= port_b;
                    o_err_a <= ~port_b & acc_err;
                    o_err_b <= port_b & acc_err;
                    state   <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory read data only arrives during RESP, so it is steered
    // combinationally to the acked port for legal loads.
    assign o_rdata_a = (o_ack_a && !acc_we && !acc_err) ? i_mem_rdata : 32'h0000_0000;
    assign o_rdata_b = (o_ack_b && !acc_we && !acc_err) ? i_mem_rdata : 32'h0000_0000;

endmodule
`default_nettype wire
